// File: rtl/addr_gen_pkg.sv
// Shared definitions for the burst address generator.
//   - source-index constants for the packed source bus
//   - ar_size encodings and a decode to a byte-shift amount
//   - FSM state type
package addr_gen_pkg;

  localparam int unsigned AR_ALU_SEL  = 0;
  localparam int unsigned AR_PC_SEL   = 1;
  localparam int unsigned AR_PC_4_SEL = 2;

  typedef enum logic [1:0] {
    SizeByte  = 2'b00,
    SizeHalf  = 2'b01,
    SizeWord  = 2'b10,
    SizeWordX = 2'b11  // alias of SizeWord
  } ar_size_e;

  typedef enum logic {
    StIdle,
    StActive
  } ar_state_e;

  // log2 of the per-beat step in bytes.
  function automatic logic [1:0] size_shift(ar_size_e size);
    logic [1:0] shift;
    unique case (size)
      SizeByte: shift = 2'd0;
      SizeHalf: shift = 2'd1;
      default:  shift = 2'd2;
    endcase
    return shift;
  endfunction

endpackage

// File: rtl/addr_gen_step.sv
// Combinational next-beat address calculation.
//   addr_i      : current beat address
//   size_i      : captured step encoding
//   len_i       : captured burst length (beats minus one)
//   wrap_i      : captured wrap request
//   next_addr_o : address of the following beat
// A wrap request only takes effect when the beat count is a power of two >= 2;
// otherwise the burst increments linearly modulo 2^ADDR_W.
module addr_gen_step
  import addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  ar_size_e          size_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              wrap_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [1:0]        shift;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] mask;
  logic [LEN_W:0]    beats;
  logic              pow2;

  always_comb begin
    shift = size_shift(size_i);
    step  = ADDR_W'(1) << shift;
    inc   = addr_i + step;
    beats = {1'b0, len_i} + (LEN_W + 1)'(1);
    pow2  = (len_i != '0) && ((beats & (beats - (LEN_W + 1)'(1))) == '0);
    // Wrap window is beats*step bytes; only bits inside it may change.
    span  = ADDR_W'(beats) << shift;
    mask  = span - ADDR_W'(1);
    if (wrap_i && pow2) begin
      next_addr_o = (addr_i & ~mask) | (inc & mask);
    end else begin
      next_addr_o = inc;
    end
  end

endmodule

// File: rtl/addr_gen.sv
// Burst address generator.
//   sysclk, sysrst_n : clock, asynchronous active-low reset
//   ar_src_bus/sel   : packed candidate start addresses and selector
//   ar_load          : start a burst (IDLE only)
//   ar_burst_len     : beats minus one
//   ar_size/ar_wrap  : step size and wrapping-burst request
//   ar_abort         : terminate the burst (beats load and ready)
//   ar_ready         : memory accepts the current address
//   ar_addr/ar_valid : registered current address and its qualifier
//   ar_busy          : burst in progress
//   ar_done          : one-cycle pulse after the final beat is accepted
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned N_SRC  = 3,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                      sysclk,
  input  logic                      sysrst_n,
  input  logic [N_SRC*ADDR_W-1:0]   ar_src_bus,
  input  logic [$clog2(N_SRC)-1:0]  ar_src_sel,
  input  logic                      ar_load,
  input  logic [LEN_W-1:0]          ar_burst_len,
  input  logic [1:0]                ar_size,
  input  logic                      ar_wrap,
  input  logic                      ar_abort,
  input  logic                      ar_ready,
  output logic [ADDR_W-1:0]         ar_addr,
  output logic                      ar_valid,
  output logic                      ar_busy,
  output logic                      ar_done
);

  localparam int unsigned SelW = $clog2(N_SRC);

  ar_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  ar_size_e          size_q, size_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] next_addr;

  // Out-of-range selectors fall through to source 0.
  always_comb begin
    src_addr = ar_src_bus[ADDR_W-1:0];
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (ar_src_sel == SelW'(k)) begin
        src_addr = ar_src_bus[k*ADDR_W +: ADDR_W];
      end
    end
  end

  addr_gen_step #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_step (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .wrap_i      (wrap_q),
    .next_addr_o (next_addr)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    size_d  = size_q;
    wrap_d  = wrap_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ar_load && !ar_abort) begin
          state_d = StActive;
          addr_d  = src_addr;
          cnt_d   = ar_burst_len;
          len_d   = ar_burst_len;
          size_d  = ar_size_e'(ar_size);
          wrap_d  = ar_wrap;
        end
      end
      StActive: begin
        if (ar_abort) begin
          state_d = StIdle;
        end else if (ar_ready) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            addr_d = next_addr;
            cnt_d  = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      size_q  <= SizeByte;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      size_q  <= size_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign ar_addr  = addr_q;
  assign ar_valid = (state_q == StActive);
  assign ar_busy  = (state_q == StActive);
  assign ar_done  = done_q;

endmodule

// File: tb/tb_addr_gen.sv
module tb_addr_gen;

  localparam int AW = 32;
  localparam int NS = 3;
  localparam int LW = 4;

  logic              sysclk;
  logic              sysrst_n;
  logic [NS*AW-1:0]  ar_src_bus;
  logic [1:0]        ar_src_sel;
  logic              ar_load;
  logic [LW-1:0]     ar_burst_len;
  logic [1:0]        ar_size;
  logic              ar_wrap;
  logic              ar_abort;
  logic              ar_ready;
  logic [AW-1:0]     ar_addr;
  logic              ar_valid;
  logic              ar_busy;
  logic              ar_done;

  addr_gen #(
    .ADDR_W (AW),
    .N_SRC  (NS),
    .LEN_W  (LW)
  ) dut (
    .sysclk       (sysclk),
    .sysrst_n     (sysrst_n),
    .ar_src_bus   (ar_src_bus),
    .ar_src_sel   (ar_src_sel),
    .ar_load      (ar_load),
    .ar_burst_len (ar_burst_len),
    .ar_size      (ar_size),
    .ar_wrap      (ar_wrap),
    .ar_abort     (ar_abort),
    .ar_ready     (ar_ready),
    .ar_addr      (ar_addr),
    .ar_valid     (ar_valid),
    .ar_busy      (ar_busy),
    .ar_done      (ar_done)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  typedef struct {
    logic [31:0] addr;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input bit last);
    beat_t b;
    b.addr = addr;
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Reference: beat i of a burst is base + i*step, reduced modulo 2^32 for
  // linear bursts, or kept inside the aligned beats*step window when wrapping.
  task automatic model_push(input logic [31:0] base, input int len, input int size,
                            input bit wrap);
    longint step, span, b, al, a;
    int beats;
    bit wr;
    step  = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    beats = len + 1;
    wr    = wrap && (beats >= 2) && ((beats & (beats - 1)) == 0);
    span  = beats * step;
    b     = longint'({32'h0, base});
    al    = b - (b % span);
    for (int i = 0; i <= len; i++) begin
      if (wr) a = al + ((b - al) + i * step) % span;
      else    a = (b + i * step) % 64'h1_0000_0000;
      push_exp(a[31:0], i == len);
    end
  endtask

  // ready_mode: 0 random, 1 always, 2 pattern 1-0-1-1...
  task automatic run_burst(input logic [NS*AW-1:0] bus, input logic [1:0] sel,
                           input int len, input int size, input bit wrap,
                           input int ready_mode, input int abort_at,
                           input bit use_model, input bit abort_at_load);
    logic [31:0] base;
    int cycles;
    int accepted;
    case (sel)
      2'd1:    base = bus[63:32];
      2'd2:    base = bus[95:64];
      default: base = bus[31:0];
    endcase
    ar_src_bus   = bus;
    ar_src_sel   = sel;
    ar_burst_len = LW'(len);
    ar_size      = 2'(size);
    ar_wrap      = wrap;
    ar_load      = 1'b1;
    ar_abort     = abort_at_load;
    ar_ready     = 1'($urandom_range(0, 1));
    if (use_model && !abort_at_load) model_push(base, len, size, wrap);
    @(posedge sysclk); #1;
    ar_load  = 1'b0;
    ar_abort = 1'b0;
    if (abort_at_load) begin
      check("abort_beats_load_busy", ar_busy, 0);
      check("abort_beats_load_valid", ar_valid, 0);
      ar_ready = 1'b0;
      return;
    end
    cycles   = 0;
    accepted = 0;
    while (ar_busy && cycles < 200) begin
      case (ready_mode)
        1:       ar_ready = 1'b1;
        2:       ar_ready = (cycles != 1);
        default: ar_ready = ($urandom_range(0, 3) != 0);
      endcase
      ar_abort = (accepted == abort_at);
      // Junk on the load-time inputs; a load while busy must be ignored.
      ar_load      = 1'($urandom_range(0, 1));
      ar_src_bus   = {$urandom(), $urandom(), $urandom()};
      ar_src_sel   = 2'($urandom_range(0, 3));
      ar_burst_len = LW'($urandom_range(0, 15));
      ar_size      = 2'($urandom_range(0, 3));
      ar_wrap      = 1'($urandom_range(0, 1));
      @(posedge sysclk); #1;
      if (ar_ready && !ar_abort) accepted++;
      cycles++;
    end
    ar_load  = 1'b0;
    ar_abort = 1'b0;
    ar_ready = 1'b0;
    check("burst_completes", (cycles < 200), 1);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: compares every presented beat against the scoreboard head.
  bit          done_next = 0;
  bit          hold_chk  = 0;
  logic [31:0] hold_addr = '0;

  initial begin
    bit exp_done;
    beat_t it;
    forever begin
      @(negedge sysclk);
      if (!sysrst_n) begin
        done_next = 0;
        hold_chk  = 0;
        continue;
      end
      exp_done  = done_next;
      done_next = 0;
      check("done_pulse", ar_done, exp_done);
      check("busy_eq_valid", ar_busy, ar_valid);
      if (hold_chk) begin
        check("idle_after_end_valid", ar_valid, 0);
        check("idle_after_end_addr", ar_addr, hold_addr);
        hold_chk = 0;
      end
      if (ar_valid) begin
        if (exp_q.size() == 0) begin
          check("valid_without_expected_beat", ar_valid, 0);
        end else begin
          check("beat_addr", ar_addr, exp_q[0].addr);
          if (ar_abort) begin
            hold_addr = exp_q[0].addr;
            hold_chk  = 1;
            exp_q.delete();
          end else if (ar_ready) begin
            it = exp_q.pop_front();
            if (it.last) begin
              done_next = 1;
              hold_chk  = 1;
              hold_addr = it.addr;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS*AW-1:0] bus;
    sysrst_n     = 1'b0;
    ar_src_bus   = '0;
    ar_src_sel   = '0;
    ar_load      = 1'b0;
    ar_burst_len = '0;
    ar_size      = '0;
    ar_wrap      = 1'b0;
    ar_abort     = 1'b0;
    ar_ready     = 1'b0;
    #2;
    check("reset_addr", ar_addr, 0);
    check("reset_valid", ar_valid, 0);
    check("reset_busy", ar_busy, 0);
    check("reset_done", ar_done, 0);
    #6;
    sysrst_n = 1'b1;

    // Linear word burst from ALU, loaded on first edge after reset release.
    push_exp(32'h0, 0); push_exp(32'h4, 0); push_exp(32'h8, 0); push_exp(32'hC, 1);
    run_burst({32'h0, 32'h0, 32'h0}, 2'd0, 3, 2, 0, 1, -1, 0, 0);

    // Wrapping burst from PC.
    push_exp(32'h1000003C, 0); push_exp(32'h10000030, 0);
    push_exp(32'h10000034, 0); push_exp(32'h10000038, 1);
    run_burst({32'h0, 32'h1000003C, 32'h0}, 2'd1, 3, 2, 1, 1, -1, 0, 0);

    // Byte burst from PC+4 with one stall cycle.
    push_exp(32'hFFFFFFFE, 0); push_exp(32'hFFFFFFFF, 1);
    run_burst({32'hFFFFFFFE, 32'h0, 32'h0}, 2'd2, 1, 0, 0, 2, -1, 0, 0);

    // Abort on the third beat with ready high.
    run_burst({32'h0, 32'h0, 32'h55555554}, 2'd0, 7, 2, 0, 1, 2, 1, 0);

    // Out-of-range selector loads source 0.
    push_exp(32'h000000A0, 1);
    run_burst({32'h111, 32'h222, 32'h000000A0}, 2'd3, 0, 2, 0, 1, -1, 0, 0);

    // Linear address wraps modulo 2^32.
    push_exp(32'hFFFFFFFC, 0); push_exp(32'h00000000, 1);
    run_burst({32'h0, 32'h0, 32'hFFFFFFFC}, 2'd0, 1, 3, 0, 1, -1, 0, 0);

    // Wrap request with three beats behaves linearly.
    push_exp(32'h2000000C, 0); push_exp(32'h20000010, 0); push_exp(32'h20000014, 1);
    run_burst({32'h0, 32'h2000000C, 32'h0}, 2'd1, 2, 2, 1, 1, -1, 0, 0);

    // Abort together with load in IDLE: nothing starts.
    run_burst({32'h0, 32'h0, 32'h1234}, 2'd0, 3, 2, 0, 1, -1, 0, 1);

    // Reset between edges in the middle of a burst.
    ar_src_bus   = {32'h0, 32'h0, 32'h00008000};
    ar_src_sel   = 2'd0;
    ar_burst_len = 4'd5;
    ar_size      = 2'd2;
    ar_wrap      = 1'b0;
    ar_load      = 1'b1;
    model_push(32'h00008000, 5, 2, 0);
    @(posedge sysclk); #1;
    ar_load  = 1'b0;
    ar_ready = 1'b1;
    @(posedge sysclk); #2;
    sysrst_n = 1'b0;
    #1;
    check("midburst_reset_addr", ar_addr, 0);
    check("midburst_reset_valid", ar_valid, 0);
    check("midburst_reset_busy", ar_busy, 0);
    check("midburst_reset_done", ar_done, 0);
    exp_q.delete();
    ar_ready = 1'b0;
    #3;
    sysrst_n = 1'b1;
    push_exp(32'h00000300, 0); push_exp(32'h00000302, 1);
    run_burst({32'h0, 32'h0, 32'h00000300}, 2'd0, 1, 1, 0, 0, -1, 0, 0);

    // Randomised bursts against the reference model.
    for (int n = 0; n < 80; n++) begin
      int len, size, abort_at, sel;
      bit wrap, al;
      bus = {$urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 4) == 0) bus[31:0] = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      sel      = $urandom_range(0, 3);
      len      = $urandom_range(0, 15);
      size     = $urandom_range(0, 3);
      wrap     = 1'($urandom_range(0, 1));
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
      al       = ($urandom_range(0, 15) == 0);
      run_burst(bus, 2'(sel), len, size, wrap, 0, abort_at, 1, al);
      repeat ($urandom_range(0, 2)) @(posedge sysclk);
      #1;
    end

    @(posedge sysclk); #1;
    @(posedge sysclk); #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
